rf_ram_ctrl: RTL and testbench
==============================

# rf_ram_ctrl

Synchronous front-end controller for the 32×8 asynchronous register-file RAM (active-low CS/OE/WS strobes, shared 8-bit data bus). It converts a single-cycle valid/ready request interface into correctly sequenced setup/strobe/hold phases on the RAM pins. It returns read data, or a write acknowledge, through a one-cycle response pulse. It sits directly upstream of the RAM and replaces hand-driven strobe sequences.

## Interface
- `ADDR_W`, 5: RAM address width (32 locations)
- `DATA_W`, 8: RAM data width
- `SETUP_CYC`, 1: cycles with CS low and address/data stable before the strobe; must be ≥1
- `STROBE_CYC`, 2: cycles with WS (write) or OE (read) low; must be ≥1
- `HOLD_CYC`, 1: cycles after the strobe rises with CS still low and address/data held; must be ≥1

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: controller idle and able to accept a request
- `req_we` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_W: target location
- `req_wdata` in DATA_W: write data
- `rsp_valid` out 1: one-cycle pulse when a transaction completes
- `rsp_we` out 1: echo of `req_we` for the completed transaction
- `rsp_rdata` out DATA_W: read data; holds its value until the next read completes
- `ram_addr` out ADDR_W: RAM address pins
- `ram_cs_n` out 1: chip select, active low
- `ram_oe_n` out 1: output enable, active low
- `ram_ws_n` out 1: write strobe, active low; the RAM latches data on its rising edge
- `ram_data_out` out DATA_W: value driven onto the RAM data bus
- `ram_data_oe` out 1: tri-state enable for `ram_data_out`; the top level resolves the inout
- `ram_data_in` in DATA_W: sampled RAM data bus

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A single phase counter, sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC), counts cycles within each phase.
- `req_ready` = 1 only in IDLE. Acceptance happens on `req_valid && req_ready`. It latches `req_we`, `req_addr` and `req_wdata` and moves to SETUP.
- SETUP: `ram_cs_n`=0 and `ram_addr`=latched address. For a write, `ram_data_oe`=1. After SETUP_CYC cycles the FSM moves to STROBE.
- STROBE:
  - Write: `ram_ws_n`=0.
  - Read: `ram_oe_n`=0 and `ram_data_oe`=0.
  - On the last STROBE cycle of a read, `ram_data_in` is registered into `rsp_rdata`.
  - After STROBE_CYC cycles the FSM moves to HOLD.
- HOLD: all strobes high, `ram_cs_n`=0, and address and write data held. After HOLD_CYC cycles the FSM moves to IDLE.
- `rsp_valid` and `rsp_we` are asserted in the first IDLE cycle after HOLD.
- Invariants, which must hold in every cycle:
  - `ram_ws_n` and `ram_oe_n` are never both 0.
  - `ram_data_oe`=1 implies `ram_oe_n`=1.
  - `ram_data_oe` is 1 only during a write, from SETUP through HOLD.
  - Every strobe falls and rises while `ram_cs_n`=0.
- IDLE: `ram_cs_n`, `ram_oe_n` and `ram_ws_n` are all 1, and `ram_data_oe`=0. `ram_addr` and `ram_data_out` keep their last values.
- `req_valid` while busy is ignored; no queueing.
- Addresses 0 to 31 are all valid, with no wrap logic; the address is passed through unchanged.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_we`=0, `rsp_rdata`=0, `ram_addr`=0, `ram_cs_n`=`ram_oe_n`=`ram_ws_n`=1, `ram_data_out`=0, `ram_data_oe`=0, state IDLE.
- Outputs are registered. No output has a combinational path from request inputs, except `req_ready`, which is decoded from state.
- Busy time is SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (4 by default) after the acceptance edge.
- `rsp_valid` goes high in the following cycle, which is 5 cycles after acceptance by default. `req_ready` is 1 in that same cycle, so a back-to-back request can be accepted there.
- Sustained throughput is one transaction per SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
- Reset mid-operation:
  - The FSM returns to IDLE immediately, without waiting for a clock edge, and all strobes go high.
  - `ram_data_oe` goes to 0 and no response is issued.
  - A write interrupted during STROBE may or may not commit, because the WS rise is forced by reset. This is accepted behaviour.

## Structure
- Shared package `rf_ram_pkg` holds: `ADDR_W`, `DATA_W`, the default phase-length constants, and the FSM state enum `rf_ram_state_t`. The RAM model and the testbench import the same package.
- No sub-module is needed: the FSM, phase counter and datapath registers live in one module.
- The top level builds the inout: `ram_data = ram_data_oe ? ram_data_out : 'z`.

## Test plan
- Write 0xA5 to address 3, then read address 3. Required response:
  - `ram_ws_n` low for exactly 2 cycles, bracketed by `ram_cs_n` low.
  - Read `rsp_rdata`=0xA5 with `rsp_we`=0.
  - Each `rsp_valid` fires 5 cycles after acceptance.
- Write data = address to all 32 locations back-to-back, with `req_valid` held high, then read all 32. Required response:
  - Every read returns its address value (0x00 to 0x1F).
  - A new acceptance occurs every 5 cycles.
  - Location 31 returns 0x1F.
- Hold `req_valid` high with changing address/data while the controller is busy. Required response:
  - `req_ready`=0 and no extra acceptance.
  - `ram_addr` and `ram_data_out` stay stable through HOLD.
- Bus contention check on every cycle of mixed random reads and writes: assert the invariants, in particular that `ram_data_oe` and `!ram_oe_n` are never both 1.
- Assert `rst` during the STROBE of a read. Required response:
  - Strobes are 1 and `ram_data_oe`=0 before the next clock edge.
  - `rsp_valid` never pulses and `rsp_rdata`=0.
  - The next request after reset completes normally.
- Override the parameters with SETUP_CYC=2, STROBE_CYC=1, HOLD_CYC=3. Required response: phase lengths match exactly, and `rsp_valid` arrives 7 cycles after acceptance.

Source files
------------

// File: rtl/rf_ram_pkg.sv
// -----------------------------------------------------------------------------
// rf_ram_pkg
// Shared definitions for the 32x8 register-file RAM front end: bus widths,
// default phase lengths of the strobe sequence, and the controller FSM state
// type. Imported by the controller, the RAM model and the testbench.
// -----------------------------------------------------------------------------
package rf_ram_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    // Default lengths, in clk cycles, of the three bus phases.
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } rf_ram_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rf_ram_ctrl.sv
// -----------------------------------------------------------------------------
// rf_ram_ctrl
// Converts a valid/ready request into a setup / strobe / hold sequence on the
// pins of an asynchronous RAM with active-low CS/OE/WS, and returns a one-cycle
// response pulse (with read data for reads) once the sequence is complete.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake; ready is high only while idle
//   req_we            1 = write, 0 = read
//   req_addr/wdata    target location and write data
//   rsp_valid         one-cycle completion pulse
//   rsp_we            direction of the completed transaction
//   rsp_rdata         last read data, held until the next read completes
//   ram_addr          RAM address pins
//   ram_cs_n/oe_n/ws_n RAM strobes, active low
//   ram_data_out/oe   value and tri-state enable for the shared data bus
//   ram_data_in       sampled RAM data bus
// -----------------------------------------------------------------------------
module rf_ram_ctrl
    import rf_ram_pkg::rf_ram_state_t, rf_ram_pkg::max3,
           rf_ram_pkg::ST_IDLE, rf_ram_pkg::ST_SETUP,
           rf_ram_pkg::ST_STROBE, rf_ram_pkg::ST_HOLD;
#(
    parameter int ADDR_W     = rf_ram_pkg::ADDR_W,
    parameter int DATA_W     = rf_ram_pkg::DATA_W,
    parameter int SETUP_CYC  = rf_ram_pkg::DEF_SETUP_CYC,
    parameter int STROBE_CYC = rf_ram_pkg::DEF_STROBE_CYC,
    parameter int HOLD_CYC   = rf_ram_pkg::DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs_n,
    output logic              ram_oe_n,
    output logic              ram_ws_n,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              ram_data_oe,
    input  logic [DATA_W-1:0] ram_data_in
);

    // One counter serves all phases, so it is sized for the longest one.
    localparam int CNT_MAX = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

    rf_ram_state_t     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cs_n;
    logic              r_oe_n;
    logic              r_ws_n;
    logic              r_data_oe;
    logic              r_rsp_valid;
    logic              r_rsp_we;
    logic [DATA_W-1:0] r_rsp_rdata;

    // Every pin value is set on the edge that enters the phase it belongs to,
    // so all RAM-side outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Strobes are forced high asynchronously so the RAM bus is
            // released without waiting for a clock edge.
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cs_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_ws_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop in this
            // block samples pre-edge values regardless of statement order.
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // req_ready is high in this state, so valid alone accepts.
                    if (req_valid) begin
                        r_state   <= ST_SETUP;
                        r_cnt     <= '0;
                        r_we      <= req_we;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_cs_n    <= 1'b0;
                        r_data_oe <= req_we;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state <= ST_STROBE;
                        r_cnt   <= '0;
                        if (r_we) begin
                            r_ws_n <= 1'b0;
                        end else begin
                            r_oe_n <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == STROBE_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        r_ws_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        // Sample while OE is still low in this last cycle.
                        if (!r_we) begin
                            r_rsp_rdata <= ram_data_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_cs_n      <= 1'b1;
                        r_data_oe   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= r_we;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_we       = r_rsp_we;
    assign rsp_rdata    = r_rsp_rdata;
    assign ram_addr     = r_addr;
    assign ram_cs_n     = r_cs_n;
    assign ram_oe_n     = r_oe_n;
    assign ram_ws_n     = r_ws_n;
    assign ram_data_out = r_wdata;
    assign ram_data_oe  = r_data_oe;

endmodule

// File: tb/tb_rf_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_ram_ctrl
// Self-checking bench for rf_ram_ctrl. A default-parameter instance is driven
// with directed and random traffic; a cycle-offset reference model derives the
// expected pin levels and responses from the acceptance cycle of each request.
// A second instance with SETUP=2/STROBE=1/HOLD=3 has its phase lengths measured.
// -----------------------------------------------------------------------------
module tb_rf_ram_ctrl;
    import rf_ram_pkg::*;

    localparam int S   = DEF_SETUP_CYC;
    localparam int T   = DEF_STROBE_CYC;
    localparam int H   = DEF_HOLD_CYC;
    localparam int TOT = S + T + H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_cs_n, ram_oe_n, ram_ws_n, ram_data_oe;
    logic [DATA_W-1:0] ram_data_out, ram_data_in;

    // Overridden instance
    logic              r2_req_valid, r2_req_ready, r2_req_we;
    logic [ADDR_W-1:0] r2_req_addr;
    logic [DATA_W-1:0] r2_req_wdata;
    logic              r2_rsp_valid, r2_rsp_we;
    logic [DATA_W-1:0] r2_rsp_rdata;
    logic [ADDR_W-1:0] r2_ram_addr;
    logic              r2_ram_cs_n, r2_ram_oe_n, r2_ram_ws_n, r2_ram_data_oe;
    logic [DATA_W-1:0] r2_ram_data_out, r2_ram_data_in;

    rf_ram_ctrl u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n),
        .ram_ws_n(ram_ws_n), .ram_data_out(ram_data_out),
        .ram_data_oe(ram_data_oe), .ram_data_in(ram_data_in)
    );

    rf_ram_ctrl #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(r2_req_valid), .req_ready(r2_req_ready), .req_we(r2_req_we),
        .req_addr(r2_req_addr), .req_wdata(r2_req_wdata),
        .rsp_valid(r2_rsp_valid), .rsp_we(r2_rsp_we), .rsp_rdata(r2_rsp_rdata),
        .ram_addr(r2_ram_addr), .ram_cs_n(r2_ram_cs_n), .ram_oe_n(r2_ram_oe_n),
        .ram_ws_n(r2_ram_ws_n), .ram_data_out(r2_ram_data_out),
        .ram_data_oe(r2_ram_data_oe), .ram_data_in(r2_ram_data_in)
    );

    // Asynchronous RAM devices: drive data while CS and OE are low, latch on
    // the WS rising edge.
    logic [DATA_W-1:0] ram_mem  [32];
    logic [DATA_W-1:0] ram2_mem [32];

    assign ram_data_in    = (!ram_cs_n && !ram_oe_n) ? ram_mem[ram_addr] : '0;
    assign r2_ram_data_in = (!r2_ram_cs_n && !r2_ram_oe_n) ? ram2_mem[r2_ram_addr] : '0;

    always @(posedge ram_ws_n)
        if (!ram_cs_n && ram_data_oe) ram_mem[ram_addr] = ram_data_out;
    always @(posedge r2_ram_ws_n)
        if (!r2_ram_cs_n && r2_ram_data_oe) ram2_mem[r2_ram_addr] = r2_ram_data_out;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: expected pin levels follow from the offset d of the
    // current cycle from the acceptance cycle of the transaction in flight.
    // ------------------------------------------------------------------
    int                cyc = 0;
    int                acc = -100;
    int                n_acc = 0;
    logic              cur_we = 1'b0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [DATA_W-1:0] cur_data = '0;
    logic [DATA_W-1:0] cur_exp = '0;
    logic [DATA_W-1:0] exp_rdata = '0;
    logic [DATA_W-1:0] model_mem [32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        int   d;
        logic active, ws_exp, oe_exp;
        if (rst) begin
            acc       = -100;
            exp_rdata = '0;
        end else begin
            d      = cyc - acc;
            active = (d >= 1) && (d <= TOT);
            ws_exp = active && cur_we && (d >= S + 1) && (d <= S + T);
            oe_exp = active && !cur_we && (d >= S + 1) && (d <= S + T);
            if (!cur_we && d == S + T + 1) exp_rdata = cur_exp;

            check("req_ready", 32'(req_ready), 32'(!active));
            check("cs_n", 32'(ram_cs_n), 32'(!active));
            check("ws_n", 32'(ram_ws_n), 32'(!ws_exp));
            check("oe_n", 32'(ram_oe_n), 32'(!oe_exp));
            check("data_oe", 32'(ram_data_oe), 32'(active && cur_we));
            check("contention", 32'(ram_data_oe && !ram_oe_n), 32'(0));
            check("both_strobes", 32'(!ram_ws_n && !ram_oe_n), 32'(0));
            if (active) begin
                check("addr_stable", 32'(ram_addr), 32'(cur_addr));
                if (cur_we) check("wdata_stable", 32'(ram_data_out), 32'(cur_data));
            end
            check("rsp_valid", 32'(rsp_valid), 32'(d == TOT + 1));
            if (d == TOT + 1) check("rsp_we", 32'(rsp_we), 32'(cur_we));
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));

            if (req_valid && req_ready) begin
                acc      = cyc;
                cur_we   = req_we;
                cur_addr = req_addr;
                cur_data = req_wdata;
                if (req_we) model_mem[req_addr] = req_wdata;
                else        cur_exp = model_mem[req_addr];
                n_acc++;
            end
        end
    end

    // Present a request and return one cycle after it is accepted.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input bit keep);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One transaction on the overridden instance with phase-length measurement.
    task automatic dut2_txn(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
        int   n_setup, n_strobe, n_hold, t_rsp, n_cont;
        bit   ok, seen_strobe, seen_rsp;
        logic strobe, rsp_we_seen;
        n_setup = 0; n_strobe = 0; n_hold = 0; t_rsp = -1; n_cont = 0;
        ok = 1'b0; seen_strobe = 1'b0; seen_rsp = 1'b0; rsp_we_seen = 1'b0;
        r2_req_valid = 1'b1;
        r2_req_we    = we;
        r2_req_addr  = a;
        r2_req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r2_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("dut2_req_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        r2_req_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            strobe = we ? !r2_ram_ws_n : !r2_ram_oe_n;
            if (r2_ram_data_oe && !r2_ram_oe_n) n_cont++;
            if (strobe) begin
                n_strobe++;
                seen_strobe = 1'b1;
            end else if (!r2_ram_cs_n) begin
                if (seen_strobe) n_hold++;
                else             n_setup++;
            end
            if (r2_rsp_valid && !seen_rsp) begin
                seen_rsp    = 1'b1;
                t_rsp       = i;
                rsp_we_seen = r2_rsp_we;
            end
        end
        check("dut2_setup_len", 32'(n_setup), 32'(2));
        check("dut2_strobe_len", 32'(n_strobe), 32'(1));
        check("dut2_hold_len", 32'(n_hold), 32'(3));
        check("dut2_rsp_latency", 32'(t_rsp), 32'(7));
        check("dut2_rsp_we", 32'(rsp_we_seen), 32'(we));
        check("dut2_contention", 32'(n_cont), 32'(0));
        if (!we) check("dut2_rdata", 32'(r2_rsp_rdata), 32'(exp_rd));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int prev, base;
        logic [ADDR_W-1:0] ra;
        logic              rw;

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        r2_req_valid = 1'b0; r2_req_we = 1'b0; r2_req_addr = '0; r2_req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            ram_mem[i]   = DATA_W'($urandom);
            model_mem[i] = ram_mem[i];
            ram2_mem[i]  = '0;
        end

        // Reset values, observed before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_we", 32'(rsp_we), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_ram_addr", 32'(ram_addr), 32'(0));
        check("rst_strobes", 32'({ram_cs_n, ram_oe_n, ram_ws_n}), 32'(3'b111));
        check("rst_data_out", 32'(ram_data_out), 32'(0));
        check("rst_data_oe", 32'(ram_data_oe), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Directed write then read of address 3.
        do_req(1'b1, 5'd3, 8'hA5, 1'b0);
        do_req(1'b0, 5'd3, 8'h00, 1'b0);
        idle(6);
        check("t1_rdata", 32'(rsp_rdata), 32'(8'hA5));

        // Back-to-back: write data = address everywhere, then read all back.
        prev = 0;
        for (int i = 0; i < 64; i++) begin
            do_req(i < 32, ADDR_W'(i % 32), DATA_W'(i % 32), 1'b1);
            if (i > 0) check("b2b_gap", 32'(acc - prev), 32'(TOT + 1));
            prev = acc;
        end
        req_valid = 1'b0;
        idle(7);
        check("loc31_rdata", 32'(rsp_rdata), 32'(8'h1F));

        // Request held with changing contents while busy.
        base      = n_acc;
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            req_we    = 1'($urandom);
            req_addr  = ADDR_W'($urandom);
            req_wdata = DATA_W'($urandom);
        end
        req_valid = 1'b0;
        check("storm_accepts", 32'(n_acc - base), 32'(40 / (TOT + 1)));
        idle(7);

        // Mixed random traffic with random idle gaps.
        for (int i = 0; i < 80; i++) begin
            idle($urandom_range(0, 3));
            do_req(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), 1'b0);
        end
        idle(7);

        // Reset during the strobe of a read.
        ra = 5'd9;
        do_req(1'b0, ra, 8'h00, 1'b0);
        for (int i = 0; i < 10 && ram_oe_n; i++) idle(1);
        check("rst_test_in_strobe", 32'(ram_oe_n), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("midrst_strobes", 32'({ram_cs_n, ram_oe_n, ram_ws_n}), 32'(3'b111));
        check("midrst_data_oe", 32'(ram_data_oe), 32'(0));
        check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("midrst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        idle(7);
        check("postrst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        rw = 1'b1;
        do_req(rw, ra, 8'h5A, 1'b0);
        do_req(1'b0, ra, 8'h00, 1'b0);
        idle(7);
        check("postrst_read", 32'(rsp_rdata), 32'(8'h5A));

        // Overridden phase lengths.
        dut2_txn(1'b1, 5'd7, 8'h3C, 8'h00);
        dut2_txn(1'b0, 5'd7, 8'h00, 8'h3C);
        dut2_txn(1'b1, 5'd31, 8'hC3, 8'h00);
        dut2_txn(1'b0, 5'd31, 8'h00, 8'hC3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
